pll_reset_sequencer: RTL and testbench

Reset and lock supervisor wrapped around the 50 MHz → 6 MHz system PLL. Runs on the 50 MHz board reference clock and drives the PLL reset input. Consumes the PLL `locked` flag and issues a clean system reset only after lock has been stable for a programmable time. Re-resets the PLL on lock loss or lock timeout, and exposes status for the recorder control logic.

---
 rtl/pll_reset_sequencer_pkg.sv | 23 ++
 rtl/pll_reset_sequencer_if.sv | 23 ++
 rtl/pll_reset_sequencer_bit_sync.sv | 21 ++
 rtl/pll_reset_sequencer.sv | 116 +++++++++++
 tb/tb_pll_reset_sequencer.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and build defaults for the PLL reset/lock supervisor.
package pll_rst_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  // Defaults for the 50 MHz -> 6 MHz system PLL build.
  localparam int unsigned LOCK_STABLE_CYCLES_DEF  = 1024;
  localparam int unsigned LOCK_TIMEOUT_CYCLES_DEF = 50000;
  localparam int unsigned PLL_RST_CYCLES_DEF      = 16;
  localparam int unsigned SYNC_STAGES_DEF         = 2;
  localparam int unsigned CNT_W_DEF               = 8;

  // Counter width for a count of n cycles; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// PLL lock input and reset/status outputs of the sequencer.
interface pll_reset_sequencer_if
  import pll_rst_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
);
  logic             locked;
  logic             pll_rst;
  logic             sys_rst_n;
  logic             ready;
  logic [CNT_W-1:0] relock_cnt;
  logic             timeout_err;

  modport master (
    input  locked,
    output pll_rst, sys_rst_n, ready, relock_cnt, timeout_err
  );

  modport slave (
    output locked,
    input  pll_rst, sys_rst_n, ready, relock_cnt, timeout_err
  );
endinterface

// File: rtl/pll_reset_sequencer_bit_sync.sv
// N-stage single-bit synchronizer with asynchronous active-low reset.
module bit_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  localparam int unsigned N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] sr;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '0;
    else        sr <= {sr[N-2:0], d};
  end

  assign q = sr[N-1];
endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset pulse generation, lock qualification and system reset release.
module pll_reset_sequencer
  import pll_rst_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYCLES  = LOCK_STABLE_CYCLES_DEF,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = LOCK_TIMEOUT_CYCLES_DEF,
  parameter int unsigned PLL_RST_CYCLES      = PLL_RST_CYCLES_DEF,
  parameter int unsigned SYNC_STAGES         = SYNC_STAGES_DEF,
  parameter int unsigned CNT_W               = CNT_W_DEF
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  pll_reset_sequencer_if.master bus
);
  localparam int unsigned ST_W = cnt_width(LOCK_STABLE_CYCLES);
  localparam int unsigned TO_W = cnt_width(LOCK_TIMEOUT_CYCLES);
  localparam int unsigned PR_W = cnt_width(PLL_RST_CYCLES);

  localparam logic [ST_W-1:0] ST_LAST = ST_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [PR_W-1:0] PR_LAST = PR_W'(PLL_RST_CYCLES - 1);

  state_t            state;
  logic              locked_s;
  logic [PR_W-1:0]   pr_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [ST_W-1:0]   st_cnt;
  logic              pll_rst_q;
  logic              sys_rst_n_q;
  logic              ready_q;
  logic [CNT_W-1:0]  relock_q;
  logic              terr_q;

  bit_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (bus.locked),
    .q     (locked_s)
  );

  // Sequencer FSM; outputs are updated together with the state they decode.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= PLL_RST;
      pr_cnt      <= '0;
      to_cnt      <= '0;
      st_cnt      <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      relock_q    <= '0;
      terr_q      <= 1'b0;
    end else begin
      case (state)
        PLL_RST: begin
          to_cnt <= '0;
          if (pr_cnt == PR_LAST) begin
            pr_cnt    <= '0;
            state     <= WAIT_LOCK;
            pll_rst_q <= 1'b0;
          end else begin
            pr_cnt <= pr_cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          to_cnt <= to_cnt + 1'b1;
          if (locked_s) begin
            st_cnt <= '0;
            state  <= STABLE;
          end else if (to_cnt == TO_LAST) begin
            state     <= PLL_RST;
            pll_rst_q <= 1'b1;
            terr_q    <= 1'b1;
          end
        end
        STABLE: begin
          // Timeout keeps running from WAIT_LOCK so a flapping lock still expires.
          to_cnt <= to_cnt + 1'b1;
          st_cnt <= st_cnt + 1'b1;
          if (to_cnt == TO_LAST) begin
            state     <= PLL_RST;
            pll_rst_q <= 1'b1;
            terr_q    <= 1'b1;
          end else if (!locked_s) begin
            state <= WAIT_LOCK;
          end else if (st_cnt == ST_LAST) begin
            state       <= RUN;
            sys_rst_n_q <= 1'b1;
            ready_q     <= 1'b1;
          end
        end
        RUN: begin
          if (!locked_s) begin
            state       <= PLL_RST;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            if (relock_q != '1) relock_q <= relock_q + 1'b1;
          end
        end
        default: begin
          state       <= PLL_RST;
          pll_rst_q   <= 1'b1;
          sys_rst_n_q <= 1'b0;
          ready_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pll_rst     = pll_rst_q;
  assign bus.sys_rst_n   = sys_rst_n_q;
  assign bus.ready       = ready_q;
  assign bus.relock_cnt  = relock_q;
  assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer with reduced timing parameters.
module tb_pll_reset_sequencer;
  localparam int unsigned LSC  = 8;
  localparam int unsigned TO   = 64;
  localparam int unsigned PRC  = 4;
  localparam int unsigned SYNC = 2;

  logic refclk;
  logic rst_n;

  pll_reset_sequencer_if #(.CNT_W(8)) bus ();

  pll_reset_sequencer #(
    .LOCK_STABLE_CYCLES  (LSC),
    .LOCK_TIMEOUT_CYCLES (TO),
    .PLL_RST_CYCLES      (PRC),
    .SYNC_STAGES         (SYNC),
    .CNT_W               (8)
  ) dut (
    .refclk (refclk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Reference model: time remaining in PLL reset, time since reset release,
  // run of consecutive qualified-lock edges, and whether the system is released.
  int unsigned     m_rel;
  int unsigned     m_acq;
  int unsigned     m_streak;
  bit              m_run;
  bit              m_te;
  int unsigned     m_rc;
  logic [SYNC-1:0] hist;

  task automatic model_reset();
    m_rel = PRC; m_acq = 0; m_streak = 0; m_run = 0; m_te = 0; m_rc = 0; hist = '0;
  endtask

  task automatic model_edge();
    logic ls;
    bit   expire;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ls   = hist[SYNC-1];
    hist = {hist[SYNC-2:0], bus.locked};
    if (m_run) begin
      if (!ls) begin
        m_run = 0;
        m_rel = PRC;
        if (m_rc < 255) m_rc++;
      end
    end else if (m_rel > 0) begin
      m_rel--;
      if (m_rel == 0) begin
        m_acq = 0;
        m_streak = 0;
      end
    end else begin
      expire = (m_acq == TO - 1) && (m_streak > 0 || !ls);
      if (expire) begin
        m_te = 1;
        m_rel = PRC;
      end else if (!ls) begin
        m_streak = 0;
      end else if (m_streak == LSC) begin
        m_run = 1;
      end else begin
        m_streak++;
      end
      m_acq = (m_acq + 1) % TO;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge refclk or negedge rst_n);
      model_edge();
    end
  end

  task automatic chk(input string name, input logic e_pr, input logic e_srn,
                     input logic e_rdy, input logic [7:0] e_rc, input logic e_te);
    tests++;
    if (bus.pll_rst !== e_pr || bus.sys_rst_n !== e_srn || bus.ready !== e_rdy ||
        bus.relock_cnt !== e_rc || bus.timeout_err !== e_te) begin
      fails++;
      $display("FAIL %s @%0t: got pll_rst=%b sys_rst_n=%b ready=%b relock_cnt=%0d timeout_err=%b, expected %b %b %b %0d %b",
               name, $time, bus.pll_rst, bus.sys_rst_n, bus.ready, bus.relock_cnt,
               bus.timeout_err, e_pr, e_srn, e_rdy, e_rc, e_te);
    end
  endtask

  task automatic chk_model(input string name);
    chk(name, (m_rel > 0) && !m_run, m_run, m_run, 8'(m_rc), m_te);
  endtask

  task automatic tick();
    @(posedge refclk);
    @(negedge refclk);
  endtask

  typedef struct {
    int unsigned cycles;
    logic        lk;
    logic        pr;
    logic        srn;
    logic        rdy;
    logic [7:0]  rc;
    logic        te;
  } vec_t;

  vec_t tbl [17];

  initial begin
    // Hold locked for N edges, then expect these outputs.
    tbl[0]  = '{3,  1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0};
    tbl[1]  = '{1,  1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
    tbl[2]  = '{10, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
    tbl[3]  = '{10, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
    tbl[4]  = '{1,  1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 1'b0};
    tbl[5]  = '{20, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 1'b0};
    tbl[6]  = '{1,  1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 1'b0};
    tbl[7]  = '{1,  1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 1'b0};
    tbl[8]  = '{1,  1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0};
    tbl[9]  = '{3,  1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0};
    tbl[10] = '{1,  1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0};
    tbl[11] = '{63, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0};
    tbl[12] = '{1,  1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1};
    tbl[13] = '{3,  1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1};
    tbl[14] = '{1,  1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1};
    tbl[15] = '{63, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1};
    tbl[16] = '{1,  1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1};

    rst_n = 1'b0;
    bus.locked = 1'b0;
    repeat (2) tick();
    chk("reset", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);

    // Clean start, lock loss in RUN, then repeated timeouts.
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.locked = tbl[i].lk;
      repeat (tbl[i].cycles) tick();
      chk($sformatf("vec%0d", i), tbl[i].pr, tbl[i].srn, tbl[i].rdy, tbl[i].rc, tbl[i].te);
      chk_model($sformatf("vec%0d_model", i));
    end

    // Asynchronous reset while in STABLE clears sticky status without a clock.
    bus.locked = 1'b1;
    repeat (7) tick();
    chk("pre_async_rst", 1'b0, 1'b0, 1'b0, 8'd1, 1'b1);
    @(posedge refclk);
    #3 rst_n = 1'b0;
    #1 chk("async_rst", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    @(negedge refclk);
    bus.locked = 1'b0;
    rst_n = 1'b1;

    // Lock drop in STABLE on the same edge the timeout expires.
    repeat (59) tick();
    bus.locked = 1'b1;
    repeat (6) tick();
    bus.locked = 1'b0;
    repeat (2) tick();
    chk("simul_before", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    tick();
    chk("simul_timeout", 1'b1, 1'b0, 1'b0, 8'd0, 1'b1);
    chk_model("simul_model");

    // Flapping lock never qualifies and eventually times out.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      bus.locked = ((i % 6) < 3);
      tick();
      chk_model("flap");
      tests++;
      if (bus.ready !== 1'b0) begin
        fails++;
        $display("FAIL flap_ready @%0t: got ready=%b, expected 0", $time, bus.ready);
      end
    end
    tests++;
    if (bus.timeout_err !== 1'b1) begin
      fails++;
      $display("FAIL flap_timeout: got timeout_err=%b, expected 1", bus.timeout_err);
    end

    // Randomized lock activity with occasional asynchronous resets.
    for (int seg = 0; seg < 250; seg++) begin
      logic        v;
      int unsigned len;
      v   = ($urandom_range(0, 3) != 0);
      len = v ? $urandom_range(1, 30) : $urandom_range(1, 8);
      if ($urandom_range(0, 49) == 0) begin
        #2 rst_n = 1'b0;
        #1 chk_model("rand_rst");
        @(negedge refclk);
        rst_n = 1'b1;
      end
      bus.locked = v;
      repeat (len) begin
        tick();
        chk_model("rand");
      end
    end

    // Repeated lock loss from RUN saturates the relock counter.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 300; n++) begin
      bus.locked = 1'b1;
      repeat (20) begin
        tick();
        chk_model("relock");
      end
      bus.locked = 1'b0;
      tick();
      chk_model("relock_drop");
    end
    bus.locked = 1'b1;
    repeat (3) tick();
    chk("relock_sat", 1'b1, 1'b0, 1'b0, 8'd255, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
